// File: rtl/da_wave_send_if.sv
// Configuration channel of the DDS waveform generator.
// A valid/ready offer of frequency word, waveform select and amplitude.
//   cfg_valid  master -> slave  configuration offer
//   cfg_ready  slave -> master  shadow register empty, offer taken on valid&ready
//   cfg_freq   master -> slave  phase increment per DAC sample
//   cfg_wave   master -> slave  0 sine, 1 square, 2 triangle, 3 sawtooth
//   cfg_amp    master -> slave  amplitude, 8'hFF = unity, 0 = flat mid-scale
interface da_wave_send_if #(
    parameter int PHASE_W = 32
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [PHASE_W-1:0] cfg_freq;
    logic [1:0]         cfg_wave;
    logic [7:0]         cfg_amp;

    modport master (
        output cfg_valid, cfg_freq, cfg_wave, cfg_amp,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_freq, cfg_wave, cfg_amp,
        output cfg_ready
    );
endinterface

// File: rtl/da_wave_send.sv
// DDS waveform generator driving an 8-bit offset-binary DAC (AD9708 class).
// The DAC clock is i_clk/2; samples change on the falling DAC clock edge so
// they are settled at every rising edge. A phase accumulator selects sine
// (external ROM), square, triangle or sawtooth, and the sample is scaled
// about mid-scale. New configuration is parked in a shadow register and only
// takes effect at a phase wrap, so a waveform period is never cut short.
// Ports:
//   i_clk, i_rst   system clock, asynchronous active-high reset
//   i_en           1 generate, 0 phase held at 0 and output mid-scale
//   cfg_if         configuration valid/ready channel (slave side)
//   o_rom_addr     sine ROM address (registered)
//   i_rom_data     sine ROM word, sampled one clk after o_rom_addr changes
//   o_da_clk       DAC clock
//   o_da_data      DAC sample
//   o_wrap         1-clk pulse after the tick on which the phase overflowed
//
// Config shadow FSM
//   state        | meaning
//   CFG_IDLE     | shadow empty, cfg_ready high
//   CFG_PEND     | shadow loaded, waiting for wrap (or en=0) to apply
//   CFG_APPLIED  | shadow just copied to active, cfg_ready returns next clk
module da_wave_send #(
    parameter int PHASE_W = 32,
    parameter int DATA_W  = 8,
    parameter int ROM_AW  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    da_wave_send_if.slave     cfg_if,
    output logic [ROM_AW-1:0] o_rom_addr,
    input  logic [DATA_W-1:0] i_rom_data,
    output logic              o_da_clk,
    output logic [DATA_W-1:0] o_da_data,
    output logic              o_wrap
);
    localparam logic [DATA_W-1:0] MID    = {1'b1, {(DATA_W-1){1'b0}}};
    localparam int                PROD_W = DATA_W + 10;

    typedef enum logic [1:0] {
        CFG_IDLE    = 2'd0,
        CFG_PEND    = 2'd1,
        CFG_APPLIED = 2'd2
    } cfg_state_t;

    cfg_state_t r_state;
    cfg_state_t w_state_nxt;

    logic               r_da_clk;
    logic [PHASE_W-1:0] r_phase;
    logic               r_wrap;
    logic [ROM_AW-1:0]  r_rom_addr;
    logic [DATA_W-1:0]  r_da_data;

    logic [PHASE_W-1:0] r_freq;
    logic [1:0]         r_wave;
    logic [7:0]         r_amp;
    logic [PHASE_W-1:0] r_sh_freq;
    logic [1:0]         r_sh_wave;
    logic [7:0]         r_sh_amp;

    logic               w_tick;
    logic [PHASE_W:0]   w_sum;
    logic               w_carry;
    logic               w_wrap_now;
    logic               w_accept;
    logic               w_apply;
    logic               w_ready;

    logic [DATA_W:0]          w_p;
    logic [DATA_W-1:0]        w_raw;
    logic signed [DATA_W:0]   w_s;
    logic signed [PROD_W-1:0] w_prod;
    logic [DATA_W-1:0]        w_scaled;
    logic [DATA_W-1:0]        w_sample;

    // The tick is the clk on which the DAC clock falls: the register is high
    // before that edge.
    assign w_tick     = r_da_clk;
    assign w_sum      = {1'b0, r_phase} + {1'b0, r_freq};
    assign w_carry    = w_sum[PHASE_W];
    assign w_wrap_now = w_tick & i_en & w_carry;

    // ---------------- config shadow FSM ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= CFG_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_apply     = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            CFG_IDLE: begin
                w_ready = 1'b1;
                if (cfg_if.cfg_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CFG_PEND;
                end
            end
            CFG_PEND: begin
                // With en low nothing is being generated, so there is no
                // period to protect and the shadow goes straight in.
                if (!i_en || w_wrap_now) begin
                    w_apply     = 1'b1;
                    w_state_nxt = CFG_APPLIED;
                end
            end
            CFG_APPLIED: w_state_nxt = CFG_IDLE;
            default:     w_state_nxt = CFG_IDLE;
        endcase
    end

    assign cfg_if.cfg_ready = w_ready;

    // ---------------- sample generation ----------------
    assign w_p = r_phase[PHASE_W-1 -: DATA_W+1];

    always_comb begin
        w_raw = i_rom_data;
        case (r_wave)
            2'd0:    w_raw = i_rom_data;
            2'd1:    w_raw = w_p[DATA_W] ? '0 : '1;
            2'd2:    w_raw = w_p[DATA_W] ? ~w_p[DATA_W-1:0] : w_p[DATA_W-1:0];
            default: w_raw = r_phase[PHASE_W-1 -: DATA_W];
        endcase
    end

    // Signed offset from mid-scale times amp/256; |result| never exceeds the
    // offset, so the sum stays inside the DAC range and low bits suffice.
    assign w_s      = $signed({1'b0, w_raw}) - $signed({1'b0, MID});
    assign w_prod   = PROD_W'(w_s) * PROD_W'($signed({1'b0, r_amp}));
    assign w_scaled = MID + DATA_W'(w_prod >>> 8);
    assign w_sample = (r_amp == 8'hFF) ? w_raw : w_scaled;

    // ---------------- datapath registers ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_da_clk   <= 1'b0;
            r_phase    <= '0;
            r_wrap     <= 1'b0;
            r_rom_addr <= '0;
            r_da_data  <= MID;
            r_freq     <= '0;
            r_wave     <= 2'd0;
            r_amp      <= 8'hFF;
            r_sh_freq  <= '0;
            r_sh_wave  <= 2'd0;
            r_sh_amp   <= 8'hFF;
        end else begin
            r_da_clk <= ~r_da_clk;

            if (!i_en) begin
                r_phase <= '0;
                r_wrap  <= 1'b0;
            end else if (w_tick) begin
                r_phase <= w_sum[PHASE_W-1:0];
                r_wrap  <= w_carry;
            end else begin
                r_wrap  <= 1'b0;
            end

            // Phase only moves on ticks, so this follows the new phase on the
            // clk after the tick and the ROM word is ready by the next tick.
            r_rom_addr <= r_phase[PHASE_W-1 -: ROM_AW];

            if (w_tick) begin
                r_da_data <= i_en ? w_sample : MID;
            end

            if (w_accept) begin
                r_sh_freq <= cfg_if.cfg_freq;
                r_sh_wave <= cfg_if.cfg_wave;
                r_sh_amp  <= cfg_if.cfg_amp;
            end

            if (w_apply) begin
                r_freq <= r_sh_freq;
                r_wave <= r_sh_wave;
                r_amp  <= r_sh_amp;
            end
        end
    end

    assign o_da_clk   = r_da_clk;
    assign o_da_data  = r_da_data;
    assign o_rom_addr = r_rom_addr;
    assign o_wrap     = r_wrap;
endmodule

// File: tb/tb_da_wave_send.sv
module tb_da_wave_send;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic       da_clk;
    logic [7:0] da_data;
    logic       wrap;

    logic [7:0] rom [256];

    int checks   = 0;
    int failures = 0;

    da_wave_send_if #(.PHASE_W(32)) cfg_if ();

    da_wave_send #(.PHASE_W(32), .DATA_W(8), .ROM_AW(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .cfg_if     (cfg_if),
        .o_rom_addr (rom_addr),
        .i_rom_data (rom_data),
        .o_da_clk   (da_clk),
        .o_da_data  (da_data),
        .o_wrap     (wrap)
    );

    always #5 clk = ~clk;

    // Synchronous ROM whose address register is the DUT's rom_addr output.
    assign rom_data = rom[rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_sample(input bit [31:0] ph, input bit [1:0] wv, input bit [7:0] amp);
        int raw, p9, n, q;
        case (wv)
            2'd0: raw = int'(rom[ph >> 24]);
            2'd1: raw = (ph < 32'h8000_0000) ? 255 : 0;
            2'd2: begin
                p9  = int'(ph >> 23);
                raw = (p9 < 256) ? p9 : 511 - p9;
            end
            default: raw = int'(ph >> 24);
        endcase
        if (amp == 8'hFF) return raw;
        n = (raw - 128) * int'(amp);
        q = (n >= 0) ? n / 256 : -((-n + 255) / 256);
        return 128 + q;
    endfunction

    bit [31:0] m_phase, m_freq, m_sh_freq;
    bit [1:0]  m_wave, m_sh_wave;
    bit [7:0]  m_amp, m_sh_amp;
    bit        m_dclk, m_wrap, m_pending, m_cooldown, m_acc, m_last_tick;
    bit        m_tick, m_wrap_now;
    longint    m_sum;
    logic [7:0] exp_q [$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_freq = 0; m_wave = 0; m_amp = 8'hFF;
            m_dclk = 0; m_wrap = 0; m_pending = 0; m_cooldown = 0;
            m_acc = 0; m_last_tick = 0;
            exp_q.delete();
        end else begin
            m_tick      = m_dclk;
            m_last_tick = m_tick;
            m_acc       = 0;
            m_sum       = longint'(m_phase) + longint'(m_freq);
            m_wrap_now  = m_tick && en && (m_sum >= 64'h1_0000_0000);
            if (m_tick)
                exp_q.push_back(en ? 8'(ref_sample(m_phase, m_wave, m_amp)) : 8'h80);
            if (m_pending && (!en || m_wrap_now)) begin
                m_freq = m_sh_freq; m_wave = m_sh_wave; m_amp = m_sh_amp;
                m_pending = 0; m_cooldown = 1;
            end else if (m_cooldown) begin
                m_cooldown = 0;
            end else if (!m_pending && cfg_if.cfg_valid) begin
                m_sh_freq = cfg_if.cfg_freq; m_sh_wave = cfg_if.cfg_wave; m_sh_amp = cfg_if.cfg_amp;
                m_pending = 1; m_acc = 1;
            end
            if (!en) m_phase = 0;
            else if (m_tick) m_phase = m_sum[31:0];
            m_wrap = m_wrap_now;
            m_dclk = !m_tick;
        end
    end

    // ---------------- monitor ----------------
    logic prev_dclk = 1'b0;
    logic [7:0] exp_d;

    always @(negedge clk) begin
        if (rst) begin
            prev_dclk = 1'b0;
        end else begin
            check("da_clk", da_clk, m_dclk);
            check("cfg_ready", cfg_if.cfg_ready, !(m_pending || m_cooldown));
            check("wrap", wrap, m_wrap);
            if (prev_dclk && !da_clk) begin
                if (exp_q.size() == 0) begin
                    check("da_data_underflow", 1, 0);
                end else begin
                    exp_d = exp_q.pop_front();
                    check("da_data", da_data, exp_d);
                end
            end
            prev_dclk = da_clk;
        end
    end

    // ---------------- stimulus ----------------
    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_sync;
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!m_last_tick && n < 8);
    endtask

    task automatic offer(input bit [31:0] f, input bit [1:0] w, input bit [7:0] a);
        int n = 0;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_freq  = f;
        cfg_if.cfg_wave  = w;
        cfg_if.cfg_amp   = a;
        do begin
            @(posedge clk); #1; n++;
        end while (!m_acc && n < 3000);
        checks++;
        if (!m_acc) begin
            failures++;
            $display("FAIL cfg_accept_timeout: no accept after %0d clks, expected accept", n);
        end
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        bit [31:0] f;
        bit [7:0]  a;
        int        r;
        for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'hA5;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_freq  = '0;
        cfg_if.cfg_wave  = '0;
        cfg_if.cfg_amp   = '0;

        run(4);
        check("rst_da_clk", da_clk, 0);
        check("rst_da_data", da_data, 8'h80);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_cfg_ready", cfg_if.cfg_ready, 1);
        check("rst_wrap", wrap, 0);
        #3 rst = 1'b0;

        run(20);

        // sawtooth, unity
        offer(32'h0100_0000, 2'd3, 8'hFF);
        run(4);
        tick_sync; en = 1'b1;
        run(1100);

        // square at half amplitude offered mid-cycle: held until wrap
        offer(32'h1000_0000, 2'd1, 8'h80);
        check("ready_low_after_accept", cfg_if.cfg_ready, 0);
        run(600);

        offer(32'h0300_0000, 2'd2, 8'h60);
        run(700);

        // sine through ROM
        offer(32'h0100_0000, 2'd0, 8'hFF);
        run(1100);

        for (int k = 0; k < 10; k++) begin
            f = $urandom | 32'h0400_0000;
            r = $urandom_range(0, 3);
            a = (r == 0) ? 8'hFF : (r == 1) ? 8'h00 : 8'($urandom);
            offer(f, 2'($urandom_range(0, 3)), a);
            run($urandom_range(100, 400));
            tick_sync;
            en = ($urandom_range(0, 3) != 0);
            run($urandom_range(20, 200));
            tick_sync;
            en = 1'b1;
        end

        // reset with a pending config
        offer(32'h0010_0000, 2'd3, 8'hFF);
        run(300);
        offer(32'h1000_0000, 2'd1, 8'h40);
        run(50);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_da_clk", da_clk, 0);
        check("midrst_da_data", da_data, 8'h80);
        check("midrst_rom_addr", rom_addr, 0);
        check("midrst_cfg_ready", cfg_if.cfg_ready, 1);
        check("midrst_wrap", wrap, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        run(300);
        check("post_rst_ready", cfg_if.cfg_ready, 1);
        check("post_rst_sine_flat", da_data, 8'(0) ^ 8'hA5);

        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
